// File: rtl/wb_stage.sv
// Writeback stage of the RV32I cached pipeline.
// Holds the MEM/WB register and waits for data-cache load responses.
// Aligns and sign/zero-extends load data, then drives the register-file
// write port. Also keeps retire and load-stall counters and a sticky
// error flag for protocol or decode faults.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_wb_en,
  input  logic [4:0]       mem_rd_index,
  input  logic [1:0]       mem_wb_sel,
  input  logic [31:0]      mem_alu_result,
  input  logic [31:0]      mem_pc_plus4,
  input  logic [2:0]       mem_funct3,
  input  logic             dc_resp_valid,
  input  logic [31:0]      dc_resp_data,
  output logic             wb_en,
  output logic [4:0]       rd_index,
  output logic [31:0]      wb_data,
  output logic             retire_pulse,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             err
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  state_t           state_q;
  logic             ld_wb_en_q;
  logic [4:0]       ld_rd_q;
  logic [2:0]       ld_funct3_q;
  logic [1:0]       ld_addr_q;

  logic             wb_en_q;
  logic [4:0]       rd_index_q;
  logic [31:0]      wb_data_q;
  logic             retire_pulse_q;
  logic [CNT_W-1:0] retire_count_q;
  logic [CNT_W-1:0] stall_count_q;
  logic             err_q;

  logic             accept_s;

  // Select the addressed byte lane and apply the load size/sign rule.
  // The undefined encodings fall back to the raw word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  addr,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'h000000, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'h0000, h};
      3'b010:  res = word;
      default: res = word;
    endcase
    return res;
  endfunction

  // A load funct3 outside the five legal encodings is a decode error.
  function automatic logic load_f3_bad(input logic [2:0] f3);
    logic bad;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
      default:                                bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign mem_ready = (state_q == IDLE);
  assign accept_s  = mem_valid & mem_ready;

  // FSM, MEM/WB register, load capture, counters and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ld_wb_en_q     <= 1'b0;
      ld_rd_q        <= 5'd0;
      ld_funct3_q    <= 3'd0;
      ld_addr_q      <= 2'd0;
      wb_en_q        <= 1'b0;
      rd_index_q     <= 5'd0;
      wb_data_q      <= 32'h0000_0000;
      retire_pulse_q <= 1'b0;
      retire_count_q <= '0;
      stall_count_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      // Write and retire are single-cycle pulses unless set below.
      wb_en_q        <= 1'b0;
      retire_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dc_resp_valid) begin
            err_q <= 1'b1;
          end
          if (accept_s) begin
            if (mem_wb_sel == SEL_LOAD) begin
              ld_wb_en_q  <= mem_wb_en;
              ld_rd_q     <= mem_rd_index;
              ld_funct3_q <= mem_funct3;
              ld_addr_q   <= mem_alu_result[1:0];
              state_q     <= WAIT_LOAD;
            end else begin
              wb_en_q        <= mem_wb_en & (mem_rd_index != 5'd0);
              rd_index_q     <= mem_rd_index;
              wb_data_q      <= (mem_wb_sel == SEL_LINK) ? mem_pc_plus4
                                                         : mem_alu_result;
              retire_pulse_q <= 1'b1;
              retire_count_q <= retire_count_q + CNT_W'(1);
            end
          end
        end
        WAIT_LOAD: begin
          stall_count_q <= stall_count_q + CNT_W'(1);
          if (dc_resp_valid) begin
            wb_en_q        <= ld_wb_en_q & (ld_rd_q != 5'd0);
            rd_index_q     <= ld_rd_q;
            wb_data_q      <= load_extract(dc_resp_data, ld_addr_q, ld_funct3_q);
            retire_pulse_q <= 1'b1;
            retire_count_q <= retire_count_q + CNT_W'(1);
            state_q        <= IDLE;
            if (load_f3_bad(ld_funct3_q)) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wb_en        = wb_en_q;
  assign rd_index     = rd_index_q;
  assign wb_data      = wb_data_q;
  assign retire_pulse = retire_pulse_q;
  assign retire_count = retire_count_q;
  assign stall_count  = stall_count_q;
  assign err          = err_q;

endmodule
